double_operand_feeder: RTL and testbench

- Upstream stage of double_adder.
- Accepts one serial stream of IEEE-754 double words, alternating operand A then operand B.
- Pairs the words, buffers up to DEPTH pairs in a FIFO, and presents each pair to the adder over its separate input_a/input_b stb/ack handshakes, A first, then B.
- Decouples a bursty source, such as a DPI or memory reader, from the adder's multi-cycle accept timing.

---
 rtl/double_operand_feeder.sv | 179 +++++++++++++++++
 tb/tb_double_operand_feeder.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_operand_feeder.sv
// Pairs a serial stream of A/B double words and feeds them to double_adder
// through a DEPTH-pair FIFO, A handshake first, then B.
module double_operand_feeder #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       in_data,
   input  logic              in_stb,
   output logic              in_ack,
   output logic [63:0]       output_a,
   output logic              output_a_stb,
   input  logic              output_a_ack,
   output logic [63:0]       output_b,
   output logic              output_b_stb,
   input  logic              output_b_ack,
   output logic [ADDR_W:0]   pair_count,
   output logic              phase
);

   localparam logic [ADDR_W:0] C_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] C_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEND_A = 2'd1,
      S_SEND_B = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [127:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W-1:0]   w_rd_sel;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     w_count_next;
   logic [63:0]         r_a_hold;
   logic                r_phase;

   logic [63:0]         r_out_a;
   logic [63:0]         r_out_b;
   logic                r_a_stb;
   logic                r_b_stb;

   logic                w_in_fire;
   logic                w_push;
   logic                w_pop;
   logic                w_load;
   logic                w_bypass;
   logic [127:0]        w_load_pair;

   // A pending A word never reserves a slot: only a full FIFO refuses input.
   assign in_ack    = rst && (r_count < C_FULL);
   assign w_in_fire = in_stb && in_ack;
   assign w_push    = w_in_fire && r_phase;
   assign w_pop     = (r_state == S_SEND_B) && output_b_ack;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase  <= 1'b0;
         r_a_hold <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_in_fire && !r_phase) begin
            r_a_hold <= in_data;
            r_phase  <= 1'b1;
         end
         if (w_push) begin
            r_phase  <= 1'b0;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_a_hold, in_data};
      end
   end

   // Load decision and head selection. When SEND_B pops the last stored pair
   // on the same edge a new pair is written, that pair is taken from the
   // input path since the array write has not landed yet.
   always_comb begin
      w_load   = 1'b0;
      w_bypass = 1'b0;
      w_rd_sel = r_rd_ptr;
      case (r_state)
         S_IDLE: begin
            w_load = (r_count != '0);
         end
         S_SEND_B: begin
            w_rd_sel = r_rd_ptr + 1'b1;
            if (output_b_ack) begin
               w_load   = (r_count > C_ONE) || w_push;
               w_bypass = (r_count == C_ONE) && w_push;
            end
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
      w_load_pair = w_bypass ? {r_a_hold, in_data} : r_mem[w_rd_sel];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_load) begin
               w_state_next = S_SEND_A;
            end
         end
         S_SEND_A: begin
            if (output_a_ack) begin
               w_state_next = S_SEND_B;
            end
         end
         S_SEND_B: begin
            if (output_b_ack) begin
               w_state_next = w_load ? S_SEND_A : S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a_stb <= 1'b0;
         r_b_stb <= 1'b0;
         r_out_a <= '0;
         r_out_b <= '0;
      end else begin
         r_a_stb <= (w_state_next == S_SEND_A);
         r_b_stb <= (w_state_next == S_SEND_B);
         if (w_load) begin
            r_out_a <= w_load_pair[127:64];
            r_out_b <= w_load_pair[63:0];
         end
      end
   end

   assign output_a     = r_out_a;
   assign output_b     = r_out_b;
   assign output_a_stb = r_a_stb;
   assign output_b_stb = r_b_stb;
   assign pair_count   = r_count;
   assign phase        = r_phase;

endmodule

// File: tb/tb_double_operand_feeder.sv
// Scoreboard bench for double_operand_feeder: source-side pairing model feeds
// a queue that is checked against every adder-side A/B transfer.
module tb_double_operand_feeder;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   in_data = '0;
   logic          in_stb = 1'b0;
   logic          in_ack;
   logic [63:0]   output_a;
   logic          output_a_stb;
   logic          output_a_ack = 1'b0;
   logic [63:0]   output_b;
   logic          output_b_stb;
   logic          output_b_ack = 1'b0;
   logic [AW:0]   pair_count;
   logic          phase;

   int tests = 0;
   int failed = 0;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
   } pair_t;

   pair_t       exp_q[$];
   logic [63:0] tb_hold = '0;
   bit          tb_phase = 1'b0;
   int          rx_pairs = 0;

   bit a_hold_ack = 1'b0;
   bit b_manual   = 1'b0;
   bit rand_delay = 1'b0;
   bit spurious   = 1'b0;
   int a_delay = 0, b_delay = 0;
   int a_wait = 0, b_wait = 0, a_cur = 0, b_cur = 0;

   bit          mon_en = 1'b0;
   bit          expect_b = 1'b0;
   bit          prev_a_stb = 1'b0, prev_b_stb = 1'b0;
   bit          prev_a_fire = 1'b0, prev_b_fire = 1'b0;
   logic [63:0] prev_a_data = '0, prev_b_data = '0;
   int          a_len = 0, b_len = 0, last_a_len = 0, last_b_len = 0;

   double_operand_feeder #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_stb       (in_stb),
      .in_ack       (in_ack),
      .output_a     (output_a),
      .output_a_stb (output_a_stb),
      .output_a_ack (output_a_ack),
      .output_b     (output_b),
      .output_b_stb (output_b_stb),
      .output_b_ack (output_b_ack),
      .pair_count   (pair_count),
      .phase        (phase)
   );

   always #5 clk = ~clk;

   // Adder model: acks after a programmable number of stb cycles.
   always @(posedge clk) begin
      #1;
      if (output_a_stb) begin
         if (a_wait == 0) a_cur = rand_delay ? int'($urandom_range(0, 4)) : a_delay;
         output_a_ack = !a_hold_ack && (a_wait >= a_cur);
         a_wait++;
      end else begin
         a_wait = 0;
         output_a_ack = spurious && ($urandom_range(0, 1) == 1);
      end
      if (!b_manual) begin
         if (output_b_stb) begin
            if (b_wait == 0) b_cur = rand_delay ? int'($urandom_range(0, 4)) : b_delay;
            output_b_ack = (b_wait >= b_cur);
            b_wait++;
         end else begin
            b_wait = 0;
            output_b_ack = spurious && ($urandom_range(0, 1) == 1);
         end
      end else begin
         b_wait = 0;
      end
   end

   // Adder-side monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (mon_en) begin
         tests++;
         if (output_a_stb && output_b_stb) begin
            failed++;
            $display("FAIL both_stb: output_a_stb=1 output_b_stb=1, required never both");
         end
         if (prev_a_stb && !prev_a_fire) begin
            tests++;
            if (output_a_stb !== 1'b1 || output_a !== prev_a_data) begin
               failed++;
               $display("FAIL a_stable: stb=%b data=%h, required stb=1 data=%h", output_a_stb, output_a, prev_a_data);
            end
         end
         if (prev_b_stb && !prev_b_fire) begin
            tests++;
            if (output_b_stb !== 1'b1 || output_b !== prev_b_data) begin
               failed++;
               $display("FAIL b_stable: stb=%b data=%h, required stb=1 data=%h", output_b_stb, output_b, prev_b_data);
            end
         end
         if (output_a_stb) a_len++;
         if (output_b_stb) b_len++;
         if (output_a_stb && output_a_ack) begin
            tests++;
            if (expect_b) begin
               failed++;
               $display("FAIL a_order: second A transfer before B");
            end else if (exp_q.size() == 0) begin
               failed++;
               $display("FAIL a_unexpected: got A=%h, required no transfer", output_a);
            end else if (output_a !== exp_q[0].a) begin
               failed++;
               $display("FAIL a_data: got %h, required %h", output_a, exp_q[0].a);
            end
            expect_b = 1'b1;
            last_a_len = a_len;
            a_len = 0;
         end
         if (output_b_stb && output_b_ack) begin
            tests++;
            if (!expect_b) begin
               failed++;
               $display("FAIL b_order: B transfer without preceding A");
            end else if (exp_q.size() == 0) begin
               failed++;
               $display("FAIL b_unexpected: got B=%h, required no transfer", output_b);
            end else if (output_b !== exp_q[0].b) begin
               failed++;
               $display("FAIL b_data: got %h, required %h", output_b, exp_q[0].b);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            expect_b = 1'b0;
            rx_pairs++;
            last_b_len = b_len;
            b_len = 0;
         end
         prev_a_stb  = output_a_stb;
         prev_b_stb  = output_b_stb;
         prev_a_fire = output_a_stb && output_a_ack;
         prev_b_fire = output_b_stb && output_b_ack;
         prev_a_data = output_a;
         prev_b_data = output_b;
      end
   end

   // Source driver; entered and left 1 time unit after a rising edge.
   task automatic send_word(input logic [63:0] d);
      bit ok = 1'b0;
      in_data = d;
      in_stb  = 1'b1;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clk);
         if (in_ack) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            if (!tb_phase) begin
               tb_hold  = d;
               tb_phase = 1'b1;
            end else begin
               exp_q.push_back('{a: tb_hold, b: d});
               tb_phase = 1'b0;
            end
         end
      end
      in_stb = 1'b0;
      if (!ok) begin
         tests++;
         failed++;
         $display("FAIL send_timeout: word %h not accepted, required acceptance within 500 cycles", d);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || output_a_stb || output_b_stb) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 3000) begin
         tests++;
         failed++;
         $display("FAIL drain_timeout: %0d pairs pending, required 0", exp_q.size());
      end
   endtask

   task automatic wait_b_stb();
      int n = 0;
      while (!output_b_stb && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         tests++;
         failed++;
         $display("FAIL b_stb_timeout: output_b_stb=0, required 1 within 200 cycles");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      in_stb = 1'b1;
      #2;
      tests++;
      if (in_ack !== 1'b0 || output_a_stb !== 1'b0 || output_b_stb !== 1'b0) begin
         failed++;
         $display("FAIL reset_strobes: in_ack=%b a_stb=%b b_stb=%b, required 0 0 0", in_ack, output_a_stb, output_b_stb);
      end
      tests++;
      if (output_a !== 64'h0 || output_b !== 64'h0 || pair_count !== '0 || phase !== 1'b0) begin
         failed++;
         $display("FAIL reset_state: a=%h b=%h count=%0d phase=%b, required 0 0 0 0", output_a, output_b, pair_count, phase);
      end
      in_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      tests++;
      if (in_ack !== 1'b1) begin
         failed++;
         $display("FAIL reset_release_ack: in_ack=%b, required 1", in_ack);
      end
      mon_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_pair();
      send_word(64'h3FF0000000000000);
      tests++;
      if (phase !== 1'b1 || pair_count !== 3'd0) begin
         failed++;
         $display("FAIL single_after_a: phase=%b count=%0d, required 1 0", phase, pair_count);
      end
      send_word(64'h4000000000000000);
      tests++;
      if (phase !== 1'b0 || pair_count !== 3'd1 || output_a_stb !== 1'b0) begin
         failed++;
         $display("FAIL single_after_b: phase=%b count=%0d a_stb=%b, required 0 1 0", phase, pair_count, output_a_stb);
      end
      @(posedge clk);
      #1;
      tests++;
      if (output_a_stb !== 1'b1 || output_a !== 64'h3FF0000000000000) begin
         failed++;
         $display("FAIL single_a_present: stb=%b a=%h, required 1 3ff0000000000000", output_a_stb, output_a);
      end
      @(posedge clk);
      #1;
      tests++;
      if (output_a_stb !== 1'b0 || output_b_stb !== 1'b1 || output_b !== 64'h4000000000000000) begin
         failed++;
         $display("FAIL single_b_present: a_stb=%b b_stb=%b b=%h, required 0 1 4000000000000000", output_a_stb, output_b_stb, output_b);
      end
      @(posedge clk);
      #1;
      tests++;
      if (output_b_stb !== 1'b0 || pair_count !== 3'd0) begin
         failed++;
         $display("FAIL single_done: b_stb=%b count=%0d, required 0 0", output_b_stb, pair_count);
      end
   endtask

   task automatic test_fill_full();
      a_hold_ack = 1'b1;
      for (int i = 0; i < 8; i++) send_word(64'hA000000000000000 + 64'(i));
      tests++;
      if (pair_count !== 3'd4 || in_ack !== 1'b0 || phase !== 1'b0) begin
         failed++;
         $display("FAIL fill_full: count=%0d in_ack=%b phase=%b, required 4 0 0", pair_count, in_ack, phase);
      end
      in_data = 64'hB000000000000009;
      in_stb  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (phase !== 1'b0 || pair_count !== 3'd4 || in_ack !== 1'b0) begin
         failed++;
         $display("FAIL fill_refuse: phase=%b count=%0d in_ack=%b, required 0 4 0", phase, pair_count, in_ack);
      end
      a_hold_ack = 1'b0;
      send_word(64'hB000000000000009);
      tests++;
      if (phase !== 1'b1 || pair_count !== 3'd3) begin
         failed++;
         $display("FAIL fill_ninth: phase=%b count=%0d, required 1 3", phase, pair_count);
      end
      send_word(64'hB00000000000000A);
      wait_drain();
      tests++;
      if (pair_count !== 3'd0) begin
         failed++;
         $display("FAIL fill_drain: count=%0d, required 0", pair_count);
      end
   endtask

   task automatic test_stall();
      a_delay = 5;
      b_delay = 3;
      send_word(64'hC00921FB54442D18);
      send_word(64'h7FF8000000000123);
      wait_drain();
      tests++;
      if (last_a_len != 6 || last_b_len != 4) begin
         failed++;
         $display("FAIL stall_len: a_stb cycles=%0d b_stb cycles=%0d, required 6 4", last_a_len, last_b_len);
      end
      a_delay = 0;
      b_delay = 0;
   endtask

   task automatic test_back_to_back();
      int rx0;
      b_manual     = 1'b1;
      output_b_ack = 1'b0;
      send_word(64'h1111); send_word(64'h2222);
      send_word(64'h3333); send_word(64'h4444);
      send_word(64'h5555);
      wait_b_stb();
      tests++;
      if (pair_count !== 3'd2 || phase !== 1'b1) begin
         failed++;
         $display("FAIL b2b_setup: count=%0d phase=%b, required 2 1", pair_count, phase);
      end
      in_data      = 64'h6666;
      in_stb       = 1'b1;
      output_b_ack = 1'b1;
      @(posedge clk);
      #1;
      in_stb       = 1'b0;
      output_b_ack = 1'b0;
      exp_q.push_back('{a: tb_hold, b: 64'h6666});
      tb_phase = 1'b0;
      tests++;
      if (pair_count !== 3'd2 || phase !== 1'b0) begin
         failed++;
         $display("FAIL b2b_same_edge: count=%0d phase=%b, required 2 0", pair_count, phase);
      end
      b_manual = 1'b0;
      wait_drain();
      rx0 = rx_pairs;
      for (int i = 0; i < 16; i++) begin
         send_word({$urandom, $urandom});
         send_word({$urandom, $urandom});
      end
      wait_drain();
      tests++;
      if (rx_pairs - rx0 != 16 || pair_count !== 3'd0) begin
         failed++;
         $display("FAIL b2b_stream: pairs=%0d count=%0d, required 16 0", rx_pairs - rx0, pair_count);
      end
   endtask

   task automatic test_reset_mid();
      int rx0;
      b_manual     = 1'b1;
      output_b_ack = 1'b0;
      send_word(64'h11); send_word(64'h22);
      send_word(64'h33);
      wait_b_stb();
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      tests++;
      if (output_a_stb !== 1'b0 || output_b_stb !== 1'b0 || pair_count !== 3'd0 || phase !== 1'b0 || in_ack !== 1'b0) begin
         failed++;
         $display("FAIL reset_mid: a_stb=%b b_stb=%b count=%0d phase=%b in_ack=%b, required 0 0 0 0 0",
                  output_a_stb, output_b_stb, pair_count, phase, in_ack);
      end
      exp_q.delete();
      tb_phase = 1'b0;
      expect_b = 1'b0;
      prev_a_stb = 1'b0; prev_b_stb = 1'b0;
      prev_a_fire = 1'b0; prev_b_fire = 1'b0;
      a_len = 0; b_len = 0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b1;
      b_manual = 1'b0;
      mon_en   = 1'b1;
      rx0 = rx_pairs;
      send_word(64'h1);
      send_word(64'h2);
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (rx_pairs - rx0 != 1 || pair_count !== 3'd0) begin
         failed++;
         $display("FAIL reset_mid_after: pairs=%0d count=%0d, required 1 0", rx_pairs - rx0, pair_count);
      end
   endtask

   task automatic test_random();
      int rx0 = rx_pairs;
      rand_delay = 1'b1;
      spurious   = 1'b1;
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send_word({$urandom, $urandom});
      end
      wait_drain();
      rand_delay = 1'b0;
      spurious   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (rx_pairs - rx0 != 200 || pair_count !== 3'd0 || phase !== 1'b0) begin
         failed++;
         $display("FAIL random_stream: pairs=%0d count=%0d phase=%b, required 200 0 0", rx_pairs - rx0, pair_count, phase);
      end
   endtask

   initial begin
      test_reset();
      test_single_pair();
      test_fill_full();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
